// File: rtl/boot_sequencer.sv
// ---------------------------------------------------------------------------
// boot_sequencer
//
// Test-harness controller for one RV32 core. It accepts a program image as
// 32-bit words over a valid/ready stream, writes each word byte-serially into
// the core's unified memory through mem_en/mem_addr/mem_data, then releases
// the core from reset and watches gp/a7/a0 for the riscv-tests exit ecall.
// The outcome is reported as pass / fail (with failing test number) / timeout.
//
// Optional feature macro: BOOT_SEQ_CHECKSUM_EN
//   When defined, adds output load_csum, the mod-2^WIDTH sum of all accepted
//   words (overflow words included), cleared by start and by reset.
//
// Ports
//   clock, reset_n             core clock, asynchronous active-low reset
//   start                      pulse: begin a load (only in IDLE or DONE)
//   load_valid/ready/data/last program word stream, little-endian words
//   core_reset                 active-high reset to the core
//   mem_en/mem_addr/mem_data   byte write port into core memory
//   core_gp/core_a7/core_a0    observed core registers x3 / x17 / x10
//   busy, done                 status (busy = not IDLE and not DONE)
//   pass, timeout, load_err    result flags, valid while done
//   fail_test                  gp>>1 sampled at exit, 0 on pass
//   run_cycles                 saturating count of RUN/SETTLE_W cycles
// ---------------------------------------------------------------------------
module boot_sequencer #(
    parameter int WIDTH      = 32,
    parameter int MEM_DEPTH  = 4096,
    parameter int END_A7     = 93,
    parameter int SETTLE     = 4,
    parameter int MAX_CYCLES = 100000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic             core_reset,
    output logic             mem_en,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_data,
    input  logic [WIDTH-1:0] core_gp,
    input  logic [WIDTH-1:0] core_a7,
    input  logic [WIDTH-1:0] core_a0,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             load_err,
    output logic [WIDTH-1:0] fail_test,
    output logic [31:0]      run_cycles
`ifdef BOOT_SEQ_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0] load_csum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WAIT,
        S_LOAD_BYTE,
        S_RELEASE,
        S_RUN,
        S_SETTLE_W,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic [1:0]       byte_q, byte_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             last_q, last_d;
    logic             drop_q, drop_d;
    logic [3:0]       settle_q, settle_d;
    logic [31:0]      run_cycles_q, run_cycles_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic             load_err_q, load_err_d;
    logic [WIDTH-1:0] fail_test_q, fail_test_d;
`ifdef BOOT_SEQ_CHECKSUM_EN
    logic [WIDTH-1:0] csum_q, csum_d;
`endif

    logic [31:0]      rc_inc;
    logic             exit_seen;
    logic             gp_a0_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            byte_q       <= '0;
            word_q       <= '0;
            last_q       <= 1'b0;
            drop_q       <= 1'b0;
            settle_q     <= '0;
            run_cycles_q <= '0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            load_err_q   <= 1'b0;
            fail_test_q  <= '0;
`ifdef BOOT_SEQ_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            byte_q       <= byte_d;
            word_q       <= word_d;
            last_q       <= last_d;
            drop_q       <= drop_d;
            settle_q     <= settle_d;
            run_cycles_q <= run_cycles_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            load_err_q   <= load_err_d;
            fail_test_q  <= fail_test_d;
`ifdef BOOT_SEQ_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    // Saturating increment so a very long run never wraps back to small values.
    assign rc_inc    = (run_cycles_q == '1) ? run_cycles_q : run_cycles_q + 32'd1;
    assign exit_seen = (core_a7 == WIDTH'(END_A7));
    // Load overflow taints the result even if the core reports success.
    assign gp_a0_ok  = (core_gp == WIDTH'(1)) && (core_a0 == '0) && !load_err_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        byte_d       = byte_q;
        word_d       = word_q;
        last_d       = last_q;
        drop_d       = drop_q;
        settle_d     = settle_q;
        run_cycles_d = run_cycles_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        load_err_d   = load_err_q;
        fail_test_d  = fail_test_q;
`ifdef BOOT_SEQ_CHECKSUM_EN
        csum_d       = csum_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_LOAD_WAIT;
                    idx_d        = '0;
                    run_cycles_d = '0;
                    pass_d       = 1'b0;
                    timeout_d    = 1'b0;
                    load_err_d   = 1'b0;
                    fail_test_d  = '0;
`ifdef BOOT_SEQ_CHECKSUM_EN
                    csum_d       = '0;
`endif
                end
            end
            S_LOAD_WAIT: begin
                if (load_valid) begin
                    // Words past the end of memory are still consumed so the
                    // stream drains, but they never reach the write port.
                    state_d = S_LOAD_BYTE;
                    byte_d  = 2'd0;
                    word_d  = load_data;
                    last_d  = load_last;
                    drop_d  = (idx_q >= WIDTH'(MEM_DEPTH / 4));
                    if (idx_q >= WIDTH'(MEM_DEPTH / 4)) begin
                        load_err_d = 1'b1;
                    end
`ifdef BOOT_SEQ_CHECKSUM_EN
                    csum_d  = csum_q + load_data;
`endif
                end
            end
            S_LOAD_BYTE: begin
                byte_d = byte_q + 2'd1;
                if (byte_q == 2'd3) begin
                    if (!drop_q) begin
                        idx_d = idx_q + WIDTH'(1);
                    end
                    state_d = last_q ? S_RELEASE : S_LOAD_WAIT;
                end
            end
            S_RELEASE: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                run_cycles_d = rc_inc;
                // Exit is checked first: an exit on the budget's last cycle
                // still counts as a normal completion.
                if (exit_seen) begin
                    state_d  = S_SETTLE_W;
                    settle_d = '0;
                end else if (rc_inc >= 32'(MAX_CYCLES)) begin
                    state_d     = S_DONE;
                    timeout_d   = 1'b1;
                    pass_d      = 1'b0;
                    fail_test_d = core_gp >> 1;
                end
            end
            S_SETTLE_W: begin
                run_cycles_d = rc_inc;
                settle_d     = settle_q + 4'd1;
                if (settle_q == 4'(SETTLE - 1)) begin
                    state_d     = S_DONE;
                    pass_d      = gp_a0_ok;
                    fail_test_d = gp_a0_ok ? '0 : (core_gp >> 1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign load_ready = (state_q == S_LOAD_WAIT);
    assign mem_en     = (state_q == S_LOAD_BYTE) && !drop_q;
    assign mem_addr   = (state_q == S_LOAD_BYTE) ? {idx_q[WIDTH-3:0], byte_q} : '0;
    assign mem_data   = (state_q == S_LOAD_BYTE) ?
                        {{(WIDTH-8){1'b0}}, word_q[8*byte_q +: 8]} : '0;
    assign core_reset = !((state_q == S_RUN) || (state_q == S_SETTLE_W));
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign pass       = pass_q;
    assign timeout    = timeout_q;
    assign load_err   = load_err_q;
    assign fail_test  = fail_test_q;
    assign run_cycles = run_cycles_q;
`ifdef BOOT_SEQ_CHECKSUM_EN
    assign load_csum  = csum_q;
`endif

endmodule

// File: tb/tb_boot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_boot_sequencer
//
// Drives boot_sequencer (MEM_DEPTH=16, MAX_CYCLES=50, SETTLE=4) with a table
// of load/run scenarios, standing in for the core by driving gp/a7/a0
// directly, and checks reported results and the byte-serial memory writes.
// A hand-written sequence covers asynchronous reset in the middle of a load.
// ---------------------------------------------------------------------------
module tb_boot_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_last;
    logic        core_reset;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] core_gp;
    logic [31:0] core_a7;
    logic [31:0] core_a0;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic        load_err;
    logic [31:0] fail_test;
    logic [31:0] run_cycles;
`ifdef BOOT_SEQ_CHECKSUM_EN
    logic [31:0] load_csum;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] img [5];
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_cnt = 0;

    typedef struct {
        int          nwords;
        int          delay;
        logic [31:0] gp;
        logic [31:0] a0;
        logic        exp_pass;
        logic        exp_to;
        logic        exp_le;
        logic [31:0] exp_ft;
        logic [31:0] exp_rc;
        int          exp_writes;
    } vec_t;

    vec_t vecs [7];

    boot_sequencer #(
        .WIDTH(32), .MEM_DEPTH(16), .END_A7(93), .SETTLE(4), .MAX_CYCLES(50)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .load_last(load_last), .core_reset(core_reset), .mem_en(mem_en),
        .mem_addr(mem_addr), .mem_data(mem_data), .core_gp(core_gp),
        .core_a7(core_a7), .core_a0(core_a0), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .load_err(load_err),
        .fail_test(fail_test), .run_cycles(run_cycles)
`ifdef BOOT_SEQ_CHECKSUM_EN
        , .load_csum(load_csum)
`endif
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    // Records every memory byte write, sampled mid-cycle away from the edge.
    always @(negedge clock) begin
        if (mem_en && wr_cnt < 64) begin
            wr_addr[wr_cnt] = mem_addr;
            wr_data[wr_cnt] = mem_data;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Presents one word and returns at the negedge after it was captured.
    task automatic loadWord(input logic [31:0] data, input logic last);
        int t;
        load_data  = data;
        load_last  = last;
        load_valid = 1'b1;
        t = 0;
        while (!load_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!load_ready) checkOutput("load_ready_wait", {31'b0, load_ready}, 32'd1);
        @(negedge clock);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic applyStimulus(input int n, input vec_t v);
        int t;
        core_gp = '0;
        core_a0 = '0;
        core_a7 = '0;
        wr_cnt  = 0;
        pulseStart();
        checkOutput($sformatf("v%0d busy_after_start", n), {31'b0, busy}, 32'd1);
        checkOutput($sformatf("v%0d done_cleared", n), {31'b0, done}, 32'd0);
        checkOutput($sformatf("v%0d rc_cleared", n), run_cycles, 32'd0);
        for (int i = 0; i < v.nwords; i++) begin
            loadWord(img[i], i == v.nwords - 1);
        end
        t = 0;
        while (core_reset && t < 100) begin
            @(negedge clock);
            t++;
        end
        checkOutput($sformatf("v%0d reached_run", n), {31'b0, core_reset}, 32'd0);
        if (v.delay >= 0) begin
            repeat (v.delay) @(negedge clock);
            core_gp = v.gp;
            core_a0 = v.a0;
            core_a7 = 32'd93;
        end
        t = 0;
        while (!done && t < 200) begin
            @(negedge clock);
            t++;
        end
        checkOutput($sformatf("v%0d done", n), {31'b0, done}, 32'd1);
        checkOutput($sformatf("v%0d pass", n), {31'b0, pass}, {31'b0, v.exp_pass});
        checkOutput($sformatf("v%0d timeout", n), {31'b0, timeout}, {31'b0, v.exp_to});
        checkOutput($sformatf("v%0d load_err", n), {31'b0, load_err}, {31'b0, v.exp_le});
        checkOutput($sformatf("v%0d fail_test", n), fail_test, v.exp_ft);
        checkOutput($sformatf("v%0d run_cycles", n), run_cycles, v.exp_rc);
        checkOutput($sformatf("v%0d busy_done", n), {31'b0, busy}, 32'd0);
        checkOutput($sformatf("v%0d core_reset_done", n), {31'b0, core_reset}, 32'd1);
        checkOutput($sformatf("v%0d write_count", n), wr_cnt, v.exp_writes);
        for (int i = 0; i < wr_cnt && i < v.exp_writes; i++) begin
            logic [31:0] w;
            w = img[i / 4];
            checkOutput($sformatf("v%0d wr%0d_addr", n, i), wr_addr[i], i);
            checkOutput($sformatf("v%0d wr%0d_data", n, i), wr_data[i],
                        {24'b0, w[8*(i%4) +: 8]});
        end
    endtask

    initial begin
        img[0] = 32'h00100193;
        img[1] = 32'h05d00893;
        img[2] = 32'h00000513;
        img[3] = 32'hdeadbeef;
        img[4] = 32'h0badf00d;

        //            n  dly  gp  a0  pass to le  ft  rc  writes
        vecs[0] = '{3,   2,   1,  0,  1,   0, 0,  0,  7, 12};
        vecs[1] = '{3,   0,   7,  7,  0,   0, 0,  3,  5, 12};
        vecs[2] = '{1,  -1,   0,  0,  0,   1, 0,  0, 50,  4};
        vecs[3] = '{5,   3,   1,  0,  0,   0, 1,  0,  8, 16};
        vecs[4] = '{2,  49,   1,  0,  1,   0, 0,  0, 54,  8};
        vecs[5] = '{4,  48,   5,  0,  0,   0, 0,  2, 53, 16};
        vecs[6] = '{3,   1,   1,  1,  0,   0, 0,  0,  6, 12};

        reset_n    = 1'b0;
        start      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        core_gp    = '0;
        core_a7    = '0;
        core_a0    = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        checkOutput("rst core_reset", {31'b0, core_reset}, 32'd1);
        checkOutput("rst mem_en", {31'b0, mem_en}, 32'd0);
        checkOutput("rst load_ready", {31'b0, load_ready}, 32'd0);
        checkOutput("rst mem_addr", mem_addr, 32'd0);
        checkOutput("rst busy", {31'b0, busy}, 32'd0);
        checkOutput("rst done", {31'b0, done}, 32'd0);
        checkOutput("rst run_cycles", run_cycles, 32'd0);
        checkOutput("rst fail_test", fail_test, 32'd0);

        // Reset in the middle of the second word, on byte k=2.
        pulseStart();
        loadWord(img[0], 1'b0);
        loadWord(img[1], 1'b0);
        @(negedge clock);
        @(negedge clock);
        checkOutput("mid k2 mem_addr", mem_addr, 32'd6);
        checkOutput("mid k2 mem_data", mem_data, 32'h000000d0);
        checkOutput("mid k2 mem_en", {31'b0, mem_en}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("async mem_en", {31'b0, mem_en}, 32'd0);
        checkOutput("async mem_addr", mem_addr, 32'd0);
        checkOutput("async core_reset", {31'b0, core_reset}, 32'd1);
        checkOutput("async busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("post reset idle", {31'b0, busy}, 32'd0);

        // Scenario 0 starts from IDLE and must reload from address 0.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(i, vecs[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
